// File: rtl/mux_rr4.sv
// Four-input valid/ready round-robin merger with a registered output stage.
// {s1,s0} tags each output beat with the channel it came from.
module mux_rr4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             iv0,
  input  logic             iv1,
  input  logic             iv2,
  input  logic             iv3,
  output logic             ir0,
  output logic             ir1,
  output logic             ir2,
  output logic             ir3,
  output logic [WIDTH-1:0] y,
  output logic             yv,
  input  logic             yr,
  output logic             s1,
  output logic             s0
);

  logic [WIDTH-1:0] din [4];
  logic [3:0]       iv_vec;
  logic [3:0]       ir_vec;

  logic [WIDTH-1:0] y_q, y_d;
  logic             yv_q, yv_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0]       gnt;
  logic             req_any;
  logic             ld;
  logic             hs;

  assign din[0] = i0;
  assign din[1] = i1;
  assign din[2] = i2;
  assign din[3] = i3;
  assign iv_vec = {iv3, iv2, iv1, iv0};

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    logic [1:0] idx;
    gnt     = ptr_q;
    req_any = 1'b0;
    idx     = ptr_q;
    for (int off = 3; off >= 0; off--) begin
      idx = ptr_q + 2'(off);
      if (iv_vec[idx]) begin
        gnt     = idx;
        req_any = 1'b1;
      end
    end
  end

  assign ld     = ~yv_q | yr;
  assign hs     = rst_n & req_any & ld;
  assign ir_vec = hs ? (4'b0001 << gnt) : 4'b0000;

  assign ir0 = ir_vec[0];
  assign ir1 = ir_vec[1];
  assign ir2 = ir_vec[2];
  assign ir3 = ir_vec[3];

  always_comb begin
    y_d   = y_q;
    yv_d  = yv_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (hs) begin
      y_d   = din[gnt];
      sel_d = gnt;
      yv_d  = 1'b1;
      ptr_d = gnt + 2'd1;
    end else if (yr) begin
      yv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      yv_q  <= 1'b0;
      sel_q <= 2'd0;
      ptr_q <= 2'd0;
    end else begin
      y_q   <= y_d;
      yv_q  <= yv_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end

  assign y  = y_q;
  assign yv = yv_q;
  assign s1 = sel_q[1];
  assign s0 = sel_q[0];

endmodule

// File: tb/tb_mux_rr4.sv
// Bench for mux_rr4: directed vector table, hand-written corner sequences, and a
// randomized phase checked by a reference arbiter model plus a beat scoreboard.
module tb_mux_rr4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_d [4];
  logic [3:0] iv_r = 4'b0;
  logic       yr_r = 1'b0;
  logic       ir0, ir1, ir2, ir3;
  logic [7:0] y;
  logic       yv, s1, s0;

  int checks = 0;
  int errors = 0;

  logic       m_yv = 1'b0;
  logic [7:0] m_y = 8'h00;
  logic [1:0] m_sel = 2'd0;
  logic [1:0] m_ptr = 2'd0;
  logic [9:0] sb [$];

  typedef struct packed {
    logic        rn;
    logic [3:0]  iv;
    logic        yr;
    logic [31:0] d;
    logic [3:0]  exp_ir;
    logic        exp_yv;
    logic [7:0]  exp_y;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t tbl [12];

  mux_rr4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0(i_d[0]), .i1(i_d[1]), .i2(i_d[2]), .i3(i_d[3]),
    .iv0(iv_r[0]), .iv1(iv_r[1]), .iv2(iv_r[2]), .iv3(iv_r[3]),
    .ir0(ir0), .ir1(ir1), .ir2(ir2), .ir3(ir3),
    .y(y), .yv(yv), .yr(yr_r), .s1(s1), .s0(s0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rn, input logic [3:0] iv, input logic yrv,
                              input logic [31:0] d, input logic [3:0] eir, input logic eyv,
                              input logic [7:0] ey, input logic [1:0] es);
    vec_t v;
    v.rn = rn; v.iv = iv; v.yr = yrv; v.d = d;
    v.exp_ir = eir; v.exp_yv = eyv; v.exp_y = ey; v.exp_sel = es;
    return v;
  endfunction

  function automatic void arb(input logic [3:0] iv, input logic [1:0] p,
                              output logic [1:0] g, output logic any);
    logic [1:0] k;
    any = 1'b0;
    g   = 2'd0;
    for (int off = 0; off < 4; off++) begin
      k = 2'((int'(p) + off) % 4);
      if (!any && iv[k]) begin
        g   = k;
        any = 1'b1;
      end
    end
  endfunction

  // One clock: drive, check ready against the model, pop/push the scoreboard,
  // advance the model at the edge, then check the registered outputs.
  task automatic step(input logic rn, input logic [3:0] iv, input logic yrv, input logic [31:0] d,
                      output logic [3:0] ir_seen, output logic hs_o, output logic [1:0] g_o);
    logic [1:0] g;
    logic       any;
    logic [3:0] m_ir;
    logic [9:0] beat;
    @(negedge clk);
    rst_n = rn;
    iv_r  = iv;
    yr_r  = yrv;
    for (int k = 0; k < 4; k++) i_d[k] = d[8*k +: 8];
    #1;
    arb(iv, m_ptr, g, any);
    m_ir    = (rn && any && (!m_yv || yrv)) ? (4'b0001 << g) : 4'b0000;
    ir_seen = {ir3, ir2, ir1, ir0};
    hs_o    = (m_ir != 4'b0000);
    g_o     = g;
    chk("ir", 32'(ir_seen), 32'(m_ir));
    if (rn && m_yv && yrv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got beat y=%h sel=%0d expected none", y, {s1, s0});
      end else begin
        beat = sb.pop_front();
        chk("sb_y", 32'(y), 32'(beat[7:0]));
        chk("sb_sel", 32'({s1, s0}), 32'(beat[9:8]));
        $display("beat out: sel=%0d y=%h (expected sel=%0d y=%h)", {s1, s0}, y, beat[9:8], beat[7:0]);
      end
    end
    @(posedge clk);
    if (!rn) begin
      m_yv = 1'b0; m_y = 8'h00; m_sel = 2'd0; m_ptr = 2'd0;
      sb.delete();
    end else if (hs_o) begin
      sb.push_back({g, d[8*g +: 8]});
      m_yv = 1'b1; m_y = d[8*g +: 8]; m_sel = g; m_ptr = g + 2'd1;
    end else if (yrv) begin
      m_yv = 1'b0;
    end
    #1;
    chk("yv", 32'(yv), 32'(m_yv));
    chk("y", 32'(y), 32'(m_y));
    chk("sel", 32'({s1, s0}), 32'(m_sel));
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [3:0] irs;
    logic       hs;
    logic [1:0] g;
    step(v.rn, v.iv, v.yr, v.d, irs, hs, g);
    chk({name, "_ir"}, 32'(irs), 32'(v.exp_ir));
    chk({name, "_yv"}, 32'(yv), 32'(v.exp_yv));
    chk({name, "_y"}, 32'(y), 32'(v.exp_y));
    chk({name, "_sel"}, 32'({s1, s0}), 32'(v.exp_sel));
  endtask

  initial begin
    logic       pend [4];
    logic [7:0] pdata [4];
    int         wait_cnt [4];
    logic [3:0] iv;
    logic [31:0] d;
    logic       rn, yrv, hs;
    logic [3:0] irs;
    logic [1:0] g;

    for (int k = 0; k < 4; k++) i_d[k] = 8'h00;

    // reset, single channel, wrap, then full four-way rotation
    tbl[0]  = mk(1'b0, 4'hF,    1'b1, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd0);
    tbl[1]  = mk(1'b0, 4'hF,    1'b1, 32'h00000000, 4'b0000, 1'b0, 8'h00, 2'd0);
    tbl[2]  = mk(1'b1, 4'b0100, 1'b1, 32'h00A50000, 4'b0100, 1'b1, 8'hA5, 2'd2);
    tbl[3]  = mk(1'b1, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 8'hA5, 2'd2);
    tbl[4]  = mk(1'b1, 4'b1001, 1'b1, 32'hC30000C0, 4'b1000, 1'b1, 8'hC3, 2'd3);
    tbl[5]  = mk(1'b1, 4'b1001, 1'b1, 32'hC30000C0, 4'b0001, 1'b1, 8'hC0, 2'd0);
    tbl[6]  = mk(1'b1, 4'b1000, 1'b1, 32'hD3000000, 4'b1000, 1'b1, 8'hD3, 2'd3);
    tbl[7]  = mk(1'b1, 4'b1111, 1'b1, 32'h43424140, 4'b0001, 1'b1, 8'h40, 2'd0);
    tbl[8]  = mk(1'b1, 4'b1111, 1'b1, 32'h43424140, 4'b0010, 1'b1, 8'h41, 2'd1);
    tbl[9]  = mk(1'b1, 4'b1111, 1'b1, 32'h43424140, 4'b0100, 1'b1, 8'h42, 2'd2);
    tbl[10] = mk(1'b1, 4'b1111, 1'b1, 32'h43424140, 4'b1000, 1'b1, 8'h43, 2'd3);
    tbl[11] = mk(1'b1, 4'b1111, 1'b1, 32'h43424140, 4'b0001, 1'b1, 8'h40, 2'd0);

    for (int n = 0; n < 12; n++) run_vec($sformatf("tbl%0d", n), tbl[n]);

    // backpressure: 3C held for three cycles, then drain and reload ch1 together
    run_vec("bp_load", mk(1'b1, 4'b0010, 1'b1, 32'h00003C00, 4'b0010, 1'b1, 8'h3C, 2'd1));
    for (int n = 0; n < 3; n++)
      run_vec("bp_hold", mk(1'b1, 4'b0010, 1'b0, 32'h00005A00, 4'b0000, 1'b1, 8'h3C, 2'd1));
    run_vec("bp_rel", mk(1'b1, 4'b0010, 1'b1, 32'h00005A00, 4'b0010, 1'b1, 8'h5A, 2'd1));

    // reset mid-stream with requests pending, then ch0 beats ch1 on a tie
    run_vec("rs_stall", mk(1'b1, 4'b1111, 1'b0, 32'h73727170, 4'b0000, 1'b1, 8'h5A, 2'd1));
    run_vec("rs_edge",  mk(1'b0, 4'b0011, 1'b1, 32'h00006160, 4'b0000, 1'b0, 8'h00, 2'd0));
    run_vec("rs_tie0",  mk(1'b1, 4'b0011, 1'b1, 32'h00006160, 4'b0001, 1'b1, 8'h60, 2'd0));
    run_vec("rs_tie1",  mk(1'b1, 4'b0011, 1'b1, 32'h00006160, 4'b0010, 1'b1, 8'h61, 2'd1));
    run_vec("rs_drain", mk(1'b1, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 8'h61, 2'd1));

    // randomized traffic with protocol-respecting producers and a fairness bound
    for (int k = 0; k < 4; k++) begin
      pend[k] = 1'b0; pdata[k] = 8'h00; wait_cnt[k] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 50) begin
          pend[k]  = 1'b1;
          pdata[k] = 8'($urandom);
        end
      end
      iv  = {pend[3], pend[2], pend[1], pend[0]};
      d   = {pdata[3], pdata[2], pdata[1], pdata[0]};
      yrv = ($urandom_range(0, 99) < 70);
      rn  = ($urandom_range(0, 199) != 0);
      step(rn, iv, yrv, d, irs, hs, g);
      if (!rn) begin
        for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
      end else if (hs) begin
        chk("fair", 32'(wait_cnt[g] <= 3), 32'd1);
        wait_cnt[g] = 0;
        pend[g]     = 1'b0;
        for (int k = 0; k < 4; k++)
          if (pend[k] && 2'(k) != g) wait_cnt[k]++;
      end
    end

    for (int n = 0; n < 2; n++) step(1'b1, 4'b0000, 1'b1, 32'h0, irs, hs, g);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
